// File: rtl/clk_div_period_meter.sv
// Measures period and high time of an asynchronous divided clock in clk_in cycles,
// flags lock on two matching measurements and timeout when the divided clock stalls.
module clk_div_period_meter #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk_in,
    input  logic             nrst,
    input  logic             div_in,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TOUT_VAL = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEAS = 2'd1,
        ST_TOUT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic             w_rise;
    logic             w_fall;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_hpend;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_hcnt_inc;

    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_valid;
    logic             r_locked;
    logic             r_timeout;
    logic             r_have_meas;

    logic             w_start;
    logic             w_take;
    logic             w_tout_hit;
    logic             w_match;

    // Synchronizer runs regardless of clear so edge history stays coherent.
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= div_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise     = r_s2 & ~r_s3;
    assign w_fall     = ~r_s2 & r_s3;
    assign w_cnt_inc  = (&r_cnt)  ? r_cnt  : r_cnt  + 1'b1;
    assign w_hcnt_inc = (&r_hcnt) ? r_hcnt : r_hcnt + 1'b1;
    assign w_match    = r_have_meas && (r_cnt == r_period) && (r_hpend == r_high);

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_take      = 1'b0;
        w_tout_hit  = 1'b0;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = ST_MEAS;
                        w_start     = 1'b1;
                    end
                end
                ST_MEAS: begin
                    // A rise on the timeout cycle is a valid measurement.
                    if (w_rise) begin
                        w_take = 1'b1;
                    end else if (r_cnt == TOUT_VAL) begin
                        w_state_nxt = ST_TOUT;
                        w_tout_hit  = 1'b1;
                    end
                end
                ST_TOUT: begin
                    if (w_rise) begin
                        w_state_nxt = ST_MEAS;
                        w_start     = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Counters only advance while measuring; IDLE and TOUT hold them.
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            r_cnt   <= '0;
            r_hcnt  <= '0;
            r_hpend <= '0;
        end else if (clear) begin
            r_cnt   <= '0;
            r_hcnt  <= '0;
            r_hpend <= '0;
        end else if (w_start || w_take) begin
            r_cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
            r_hcnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (r_state == ST_MEAS) begin
            r_cnt <= w_cnt_inc;
            if (r_s2) begin
                r_hcnt <= w_hcnt_inc;
            end
            if (w_fall) begin
                r_hpend <= r_hcnt;
            end
        end
    end

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            r_period    <= '0;
            r_high      <= '0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_timeout   <= 1'b0;
            r_have_meas <= 1'b0;
        end else if (clear) begin
            r_period    <= '0;
            r_high      <= '0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_timeout   <= 1'b0;
            r_have_meas <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_take) begin
                r_period    <= r_cnt;
                r_high      <= r_hpend;
                r_valid     <= 1'b1;
                r_locked    <= w_match;
                r_have_meas <= 1'b1;
            end
            // First edge after IDLE/TOUT only arms the measurement.
            if (w_start) begin
                r_timeout   <= 1'b0;
                r_locked    <= 1'b0;
                r_have_meas <= 1'b0;
            end
            if (w_tout_hit) begin
                r_timeout <= 1'b1;
                r_locked  <= 1'b0;
            end
        end
    end

    assign period    = r_period;
    assign high_time = r_high;
    assign valid     = r_valid;
    assign locked    = r_locked;
    assign timeout   = r_timeout;

endmodule

// File: doc/clk_div_period_meter.md
Name: clk_div_period_meter

Overview:
Downstream monitor for the programmable clock divider output.
- Samples the divided clock in the system clock domain and measures its period and high time in system-clock cycles.
- Reports a lock when consecutive measurements match, and a timeout when the divided clock stalls.
- Results drive the status/debug outputs, so scale settings can be checked on silicon without a scope.

Parameters:
CNT_W, 16, width of the period, high-time and internal counters.
TIMEOUT_CYC, 1000, cycles without a detected rising edge before timeout is declared; must be < 2^CNT_W and > 2.

Ports:
clk_in  input  1  system clock, same clock that feeds the divider.
nrst  input  1  asynchronous active-low reset.
div_in  input  1  divided clock to measure; treated as asynchronous.
clear  input  1  synchronous restart of measurement, active high.
period  output  CNT_W  last measured period in clk_in cycles.
high_time  output  CNT_W  high-phase length belonging to the last period.
valid  output  1  one-cycle pulse when period/high_time update.
locked  output  1  two consecutive identical (period, high_time) measurements.
timeout  output  1  no rising edge within TIMEOUT_CYC cycles.

Behaviour:
Reset:
- Reset is asynchronous, active-low, on nrst.
- All outputs 0, all counters 0, synchronizer flops 0, FSM in IDLE.

Synchronizer and edge detect:
- div_in passes through 2 flops (s1, s2), then a history flop s3.
- rise = s2 & ~s3; fall = ~s2 & s3.
- Both are internal single-cycle strobes.

Counters:
- cnt: on rise, cnt <= 1; otherwise cnt <= cnt+1, saturating at all-ones.
- hcnt: on rise, hcnt <= 1; while s2=1 and no rise, hcnt <= hcnt+1, saturating.
- On fall, hpend <= hcnt.
- With rises every N cycles, cnt = N in the cycle of the next rise.

FSM states IDLE, MEAS, TOUT:
- IDLE: wait for the first rise. On rise, start counters and go to MEAS. No valid is produced.
- MEAS, on rise:
  - period <= cnt, high_time <= hpend, valid <= 1 for one cycle.
  - locked <= 1 if new {cnt, hpend} equals the previous {period, high_time} and a previous measurement exists since entering MEAS; else locked <= 0.
- MEAS, no rise, cnt reaches TIMEOUT_CYC: go to TOUT, timeout <= 1, locked <= 0. period and high_time hold.
- TOUT: on rise, timeout <= 0, restart counters, go to MEAS. The rise is treated as the first edge, so no valid is produced.

Output timing:
- Outputs are registered and update on the clk_in edge that samples the rise.
- valid is high in the same cycle the new values appear.
- The first measurement after IDLE or TOUT never sets locked.

clear:
- Return to IDLE; period, high_time, valid, locked, timeout <= 0; counters <= 0.
- Synchronizer flops keep running.
- clear wins over a simultaneous rise or timeout.

Boundaries:
- div_in frozen from reset: remain in IDLE; timeout stays 0, because the timer only runs in MEAS.
- Minimum measurable period is 2 (div_in toggling every clk_in cycle): period=2, high_time=1.
- A high phase not terminated by a fall before the next rise is impossible after synchronization.
- A rise in the same cycle as cnt==TIMEOUT_CYC counts as a rise; no timeout.

Test Plan:
- After reset, div_in period 4 (2 high/2 low), TIMEOUT_CYC=1000 -> no valid on first rise; second rise: valid pulse, period=4, high_time=2, locked=0; third rise: locked=1.
- Switch div_in to period 10, high 3 -> first new valid: period=10, high_time=3, locked=0; next valid: locked=1.
- Stop div_in low after a rise -> timeout=1 and locked=0 exactly 1000 cycles after that rise with no valid; restart at period 6 -> timeout=0 on first rise, valid with period=6 on the second rise.
- div_in toggles every cycle -> period=2, high_time=1, locked=1 from the third rise on.
- Assert clear for 1 cycle coincident with a rise while locked -> next cycle all outputs 0, FSM in IDLE; lock reacquired only on the third subsequent rise.
- Drop nrst asynchronously mid-high-phase (between clk_in edges) -> outputs 0 immediately, without waiting for a clock edge; after release, behaviour as a fresh start with no valid on the first rise.
